mips_regwrite_ctrl: RTL and testbench

- Write-port sequencer and arbiter for the MIPS register file.
- Shares the single register-file write port between two writeback requesters: req0 (ALU/R-type writeback) and req1 (load writeback).
- The register file has no reset, so after reset this block zero-fills every register before granting any requester.
- Sits directly in front of the register file's signal_reg_write / write_reg / write_data inputs.

---
 rtl/mips_regwrite_ctrl.sv | 107 ++++++++++
 tb/tb_mips_regwrite_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_regwrite_ctrl.sv
// Register-file write-port sequencer: zero-fills the file after reset,
// then round-robin arbitrates ALU and load writeback onto one port.
module mips_regwrite_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              ptr, ptr_n;
  logic              we_n;
  logic [ADDR_W-1:0] wreg_n;
  logic [DATA_W-1:0] wdata_n;
  logic              gid_n;
  logic              g0, g1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= RST_STATE;
      cnt              <= '0;
      ptr              <= 1'b0;
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
      grant_id         <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      ptr              <= ptr_n;
      signal_reg_write <= we_n;
      write_reg        <= wreg_n;
      write_data       <= wdata_n;
      grant_id         <= gid_n;
    end
  end

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    we_n    = 1'b0;
    wreg_n  = write_reg;
    wdata_n = write_data;
    gid_n   = grant_id;
    unique case (state)
      CLEAR: begin
        we_n    = 1'b1;
        wreg_n  = cnt;
        wdata_n = '0;
        cnt_n   = cnt + ADDR_W'(1);
        if (cnt == LAST) state_n = RUN;
      end
      RUN: begin
        g0 = req0_valid && (!req1_valid || !ptr);
        g1 = req1_valid && (!req0_valid || ptr);
        unique case (1'b1)
          g0: begin
            we_n    = (req0_reg != '0);
            wreg_n  = req0_reg;
            wdata_n = req0_data;
            gid_n   = 1'b0;
            ptr_n   = 1'b1;
          end
          g1: begin
            // $zero writes are accepted but never reach the file
            we_n    = (req1_reg != '0);
            wreg_n  = req1_reg;
            wdata_n = req1_data;
            gid_n   = 1'b1;
            ptr_n   = 1'b0;
          end
          default: ;
        endcase
      end
    endcase
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign busy       = (state == CLEAR);

endmodule

// File: tb/tb_mips_regwrite_ctrl.sv
// Scoreboard bench for mips_regwrite_ctrl: a behavioural model predicts
// readies and the next registered write, compared one cycle later.
module tb_mips_regwrite_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_reg = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_reg = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        signal_reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        busy;
  logic        grant_id;

  always #5 clock = ~clock;

  mips_regwrite_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .req0_valid       (req0_valid),
    .req0_reg         (req0_reg),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_reg         (req1_reg),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .signal_reg_write (signal_reg_write),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  typedef struct {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
    logic        g;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  bit          m_clear = 1'b0;
  int          m_cnt   = 0;
  bit          m_ptr   = 1'b0;
  logic [4:0]  m_reg   = '0;
  logic [31:0] m_data  = '0;
  bit          m_gid   = 1'b0;
  bit          last_g0 = 1'b0;
  bit          last_g1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    bit   g0, g1;
    exp_t e;
    @(negedge clock);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      m_clear = 1'b1;
      m_cnt   = 0;
      m_ptr   = 1'b0;
      m_reg   = '0;
      m_data  = '0;
      m_gid   = 1'b0;
      e.we = 1'b0; e.r = '0; e.d = '0; e.g = 1'b0;
    end else if (m_clear) begin
      chk("rdy0_clear", req0_ready, 0);
      chk("rdy1_clear", req1_ready, 0);
      m_reg  = 5'(m_cnt);
      m_data = '0;
      e.we = 1'b1; e.r = m_reg; e.d = '0; e.g = m_gid;
      if (m_cnt == 31) m_clear = 1'b0;
      m_cnt++;
    end else begin
      g0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
      g1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
      chk("rdy0", req0_ready, g0);
      chk("rdy1", req1_ready, g1);
      if (g0 || g1) begin
        m_reg  = g1 ? req1_reg : req0_reg;
        m_data = g1 ? req1_data : req0_data;
        m_gid  = g1;
        m_ptr  = !g1;
        e.we = (m_reg != 0);
      end else begin
        e.we = 1'b0;
      end
      e.r = m_reg; e.d = m_data; e.g = m_gid;
    end
    last_g0 = g0;
    last_g1 = g1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("we", signal_reg_write, e.we);
    chk("wreg", write_reg, e.r);
    chk("wdata", write_data, e.d);
    chk("gid", grant_id, e.g);
    chk("busy", busy, m_clear);
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    // clear sequence
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (32) cycle();
    chk("busy_after_clear", busy, 0);
    cycle();

    // single requester
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    cycle();
    idle_reqs();
    cycle();
    chk("single_wreg", write_reg, 5);

    // round-robin contention
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h22;
    repeat (4) cycle();
    idle_reqs();
    cycle();

    // $zero write dropped, then contention favours req0
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFFFFFF;
    cycle();
    chk("zero_we", signal_reg_write, 0);
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h33;
    req1_reg = 5'd4; req1_data = 32'h44;
    cycle();
    chk("zero_next_gid", grant_id, 0);
    idle_reqs();
    cycle();

    // request held through clear
    reset = 1'b1;
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h1234;
    cycle();
    reset = 1'b0;
    repeat (33) begin
      cycle();
      if (last_g0) req0_valid = 1'b0;
    end
    chk("held_wdata", write_data, 32'h1234);
    idle_reqs();
    cycle();

    // reset in the middle of clear
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midclr_busy", busy, 1);
    repeat (33) cycle();

    // random traffic obeying hold-while-stalled
    repeat (300) begin
      if (!(req0_valid && !last_g0)) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_reg   = 5'($urandom_range(0, 31));
        req0_data  = $urandom;
      end
      if (!(req1_valid && !last_g1)) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_reg   = 5'($urandom_range(0, 31));
        req1_data  = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
